// File: rtl/edge_evt_pkg.sv
// Shared constants for the edge-event arbiter: edge-mode codes and FSM state encoding.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/edge_chan_cell.sv
// One channel: Mealy edge detect, pending-event latch with direction, and sticky overflow.
module edge_chan_cell
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       level_i,
  input  logic [1:0] mode_i,
  input  logic       acc_clr_i,
  input  logic       ovf_clr_i,
  output logic       pending_o,
  output logic       pend_dir_o,
  output logic       ovf_o
);

  logic       level_q;
  logic       pending_q, pending_d;
  logic       pend_dir_q, pend_dir_d;
  logic       ovf_q, ovf_d;
  logic       rise, fall, det;
  edge_mode_e mode;

  assign mode = edge_mode_e'(mode_i);
  assign rise = level_i & ~level_q;
  assign fall = ~level_i & level_q;
  assign det  = (rise & ((mode == EDGE_RISE) || (mode == EDGE_BOTH)))
              | (fall & ((mode == EDGE_FALL) || (mode == EDGE_BOTH)));

  // A slot freed by an accept this cycle can take the new edge; otherwise it overflows.
  always_comb begin
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    ovf_d      = ovf_q & ~ovf_clr_i;
    if (det) begin
      if (!pending_q || acc_clr_i) begin
        pending_d  = 1'b1;
        pend_dir_d = rise;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (acc_clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q    <= level_i;
      pending_q  <= 1'b0;
      pend_dir_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      level_q    <= level_i;
      pending_q  <= pending_d;
      pend_dir_q <= pend_dir_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pending_o  = pending_q;
  assign pend_dir_o = pend_dir_q;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event scheduler: per-channel cells feed a round-robin valid/ready event port.
// state    | meaning
// ST_IDLE  | no event offered; picks next pending channel from rr_ptr
// ST_OFFER | event held on evt_* until accepted
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   level,
  input  logic [2*NUM_CH-1:0] edge_sel,
  input  logic [NUM_CH-1:0]   ovf_clr,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [ID_W-1:0]     evt_id,
  output logic                evt_rise,
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   ovf
);

  logic [0:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  logic              evt_rise_q, evt_rise_d;
  logic [NUM_CH-1:0] pend_dir;
  logic [NUM_CH-1:0] acc_clr;
  logic              accept;
  logic              found;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   id_next;

  assign accept = (state_q == ST_OFFER) && evt_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    assign acc_clr[c] = accept && (evt_id_q == ID_W'(c));

    edge_chan_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .level_i    (level[c]),
      .mode_i     (edge_sel[2*c+1:2*c]),
      .acc_clr_i  (acc_clr[c]),
      .ovf_clr_i  (ovf_clr[c]),
      .pending_o  (pending[c]),
      .pend_dir_o (pend_dir[c]),
      .ovf_o      (ovf[c])
    );
  end

  // First pending channel at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign id_next = (evt_id_q == ID_W'(NUM_CH - 1)) ? '0 : evt_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_rise_d  = evt_rise_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          evt_id_d    = sel;
          evt_rise_d  = pend_dir[sel];
          evt_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          rr_ptr_d    = id_next;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_rise_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_rise_q  <= evt_rise_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_rise  = evt_rise_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench: a reference model queues expected events; a negedge monitor checks them.
module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NUM_CH-1:0]   level = '0;
  logic [2*NUM_CH-1:0] edge_sel = 8'h55;
  logic [NUM_CH-1:0]   ovf_clr = '0;
  logic                evt_ready = 1'b0;
  logic                evt_valid;
  logic [ID_W-1:0]     evt_id;
  logic                evt_rise;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   ovf;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .edge_sel  (edge_sel),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_rise  (evt_rise),
    .pending   (pending),
    .ovf       (ovf)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int id;
    bit rise;
  } evt_t;
  evt_t exp_q[$];

  // Reference model: per-channel event slots plus one offered event.
  bit [NUM_CH-1:0] m_prev, m_pend, m_dir, m_ovf;
  bit              m_offer;
  int              m_off_id;
  int              m_rr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    bit [NUM_CH-1:0] old_pend, old_dir, set_ovf;
    int freed, c;
    bit r, f, hit;
    if (reset) begin
      m_prev   = level;
      m_pend   = '0;
      m_dir    = '0;
      m_ovf    = '0;
      m_offer  = 1'b0;
      m_off_id = 0;
      m_rr     = 0;
      exp_q.delete();
    end else begin
      old_pend = m_pend;
      old_dir  = m_dir;
      set_ovf  = '0;
      freed    = -1;
      if (m_offer) begin
        if (evt_ready) begin
          freed   = m_off_id;
          m_offer = 1'b0;
          m_rr    = (m_off_id + 1) % NUM_CH;
        end
      end else if (old_pend != 0) begin
        for (int k = 0; k < NUM_CH; k++) begin
          c = (m_rr + k) % NUM_CH;
          if (!m_offer && old_pend[c]) begin
            m_offer  = 1'b1;
            m_off_id = c;
            exp_q.push_back('{c, old_dir[c]});
          end
        end
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r   = level[ch] && !m_prev[ch];
        f   = !level[ch] && m_prev[ch];
        hit = (r && edge_sel[2*ch]) || (f && edge_sel[2*ch+1]);
        if (hit && (!m_pend[ch] || freed == ch)) begin
          m_pend[ch] = 1'b1;
          m_dir[ch]  = r;
        end else if (hit) begin
          set_ovf[ch] = 1'b1;
        end else if (freed == ch) begin
          m_pend[ch] = 1'b0;
        end
      end
      m_ovf  = (m_ovf & ~ovf_clr) | set_ovf;
      m_prev = level;
    end
  end

  always @(negedge clk) begin
    evt_t e;
    if (mon_en) begin
      chk("evt_valid", 32'(evt_valid), 32'(m_offer));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (evt_valid && evt_ready && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got id %0d with no expected event at %0t", evt_id, $time);
        end else begin
          e = exp_q.pop_front();
          chk("evt_id", 32'(evt_id), 32'(e.id));
          chk("evt_rise", 32'(evt_rise), 32'(e.rise));
        end
      end
    end
  end

  initial begin
    // Level high through reset produces no event.
    reset = 1'b1; level = 4'b0101; edge_sel = 8'h55; evt_ready = 1'b0;
    step(3);
    mon_en = 1'b1;
    reset = 1'b0;
    step(10);
    chk("no_evt_after_reset", 32'(evt_valid), 32'd0);

    // Single rising edge on ch2.
    evt_ready = 1'b1;
    level = 4'b0001;
    step(3);
    level = 4'b0101;
    step(1);
    chk("ch2_pending_set", 32'(pending[2]), 32'd1);
    step(1);
    chk("ch2_valid", 32'(evt_valid), 32'd1);
    chk("ch2_id", 32'(evt_id), 32'd2);
    chk("ch2_rise", 32'(evt_rise), 32'd1);
    step(1);
    chk("ch2_pending_clr", 32'(pending[2]), 32'd0);
    step(2);

    // Simultaneous rises on all channels from rr_ptr=0.
    reset = 1'b1; level = 4'b0000;
    step(2);
    reset = 1'b0;
    step(1);
    level = 4'b1111;
    step(12);
    chk("all_drained", 32'(pending), 32'd0);

    // ch1 falling-only mode with stalled consumer: overflow then clear.
    edge_sel = 8'h59; evt_ready = 1'b0;
    level = 4'b1101; step(2);
    level = 4'b1111; step(2);
    level = 4'b1101; step(2);
    chk("ch1_ovf", 32'(ovf[1]), 32'd1);
    chk("ch1_id", 32'(evt_id), 32'd1);
    chk("ch1_fall", 32'(evt_rise), 32'd0);
    ovf_clr = 4'b0010; step(1);
    ovf_clr = 4'b0000;
    chk("ch1_ovf_clr", 32'(ovf[1]), 32'd0);
    evt_ready = 1'b1;
    step(6);

    // ch0 both-edge mode: new edge in the accept cycle re-arms without overflow.
    reset = 1'b1; level = 4'b0000; edge_sel = 8'h57;
    step(2);
    reset = 1'b0; evt_ready = 1'b1;
    level = 4'b0001; step(2);
    level = 4'b0000; step(1);
    chk("ch0_rearm_pending", 32'(pending[0]), 32'd1);
    chk("ch0_rearm_ovf", 32'(ovf[0]), 32'd0);
    step(1);
    chk("ch0_second_valid", 32'(evt_valid), 32'd1);
    chk("ch0_second_dir", 32'(evt_rise), 32'd0);
    step(3);

    // Reset during an offer with three pending.
    edge_sel = 8'h55; evt_ready = 1'b0;
    level = 4'b0111; step(3);
    reset = 1'b1; step(1);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    reset = 1'b0; step(5);
    chk("rst_no_evt", 32'(evt_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      level     = level ^ 4'($urandom & $urandom);
      evt_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) edge_sel = 8'($urandom);
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      reset     = ($urandom_range(0, 199) == 0);
      step(1);
    end

    // Drain with a bounded wait.
    reset = 1'b0; ovf_clr = '0; evt_ready = 1'b1;
    for (int i = 0; i < 100 && (m_offer || m_pend != 0); i++) step(1);
    if (m_offer || m_pend != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %b still outstanding after 100 cycles", m_pend);
    end
    step(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Multi-channel edge-event scheduler. Samples NUM_CH asynchronous-to-logic (already synchronised) level inputs and detects per-channel rising/falling edges with Mealy-style detection. It latches each detected edge as a pending event and shares a single valid/ready event output among the channels using round-robin arbitration. It sits between the edge-detector front end and the interrupt/event consumer.

Parameters:
NUM_CH, 4, number of level input channels (2..16)
ID_W, 2, width of event channel index; must equal clog2(NUM_CH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
level  input  NUM_CH  per-channel level inputs, already synchronous to clk
edge_sel  input  2*NUM_CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both
ovf_clr  input  NUM_CH  write-1-to-clear pulse for sticky overflow bits
evt_valid  output  1  event offered
evt_ready  input  1  consumer accepts event when high with evt_valid
evt_id  output  ID_W  channel index of offered event
evt_rise  output  1  1 = rising edge event, 0 = falling
pending  output  NUM_CH  per-channel pending-event flags
ovf  output  NUM_CH  sticky per-channel overflow flags

Behaviour:
- Reset is synchronous, active-high. While reset is asserted: level_q <= level, so a level held high through reset produces no edge. pending=0, pend_dir=0, ovf=0, rr_ptr=0, state=IDLE, evt_valid=0, evt_id=0, evt_rise=0.
- Edge detect, combinational (Mealy) from the current input: rise[c] = level[c] & ~level_q[c]; fall[c] = ~level[c] & level_q[c]. level_q <= level every cycle.
- det[c] = (rise[c] & edge_sel[2c]) | (fall[c] & edge_sel[2c+1]).
- On det[c]:
  - If pending[c]=0, or pending[c] is cleared by an accept this cycle: pending[c] <= 1 and pend_dir[c] <= rise[c].
  - Otherwise (pending and not being accepted): pending and pend_dir are unchanged; ovf[c] <= 1.
- ovf_clr[c] clears ovf[c]. If ovf_clr[c] and a new overflow occur in the same cycle, the set wins.
- Changing edge_sel to 00 does not clear an existing pending event.
- FSM:
  - IDLE: if any pending bit is set, select the first set bit searching from rr_ptr upward with wrap-around. Register evt_id=sel, evt_rise=pend_dir[sel], evt_valid=1, then go to OFFER. If nothing is pending, stay in IDLE with evt_valid=0.
  - OFFER: evt_valid, evt_id and evt_rise are held stable until evt_valid & evt_ready. On accept: pending[evt_id] <= 0 unless a new det occurs on that channel in the same cycle. rr_ptr <= evt_id+1 (wraps to 0 after NUM_CH-1). evt_valid <= 0. Go to IDLE.
- Throughput is at most 1 event per 2 cycles (mandatory IDLE bubble). Latency from an edge on level to evt_valid is 1 cycle, i.e. evt_valid is seen at the 2nd rising clk after the change.
- If a new det arrives on the offered channel while in OFFER before accept, it is an overflow. The offered event is not modified.
- evt_ready while in IDLE is ignored.
- Reset mid-OFFER drops the offered event and all pending events. No event is emitted after reset until a fresh edge occurs.

Decomposition:
- Package edge_evt_pkg holds:
  - edge_mode_e constants (EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11)
  - state encoding (ST_IDLE, ST_OFFER)
- Sub-module edge_chan_cell: one per channel, instantiated NUM_CH times. It contains level_q, det, pending, pend_dir and ovf. Its inputs are the clear-on-accept strobe and ovf_clr.
- The top level contains the round-robin selector, rr_ptr and the FSM.

Test Plan:
- Reset with level=4'b0101 held, edge_sel all 01, release reset, hold level → evt_valid stays 0 for 10 cycles, pending=0.
- Rising edge on ch2 only, evt_ready=1 → evt_valid=1 one cycle after the edge, evt_id=2, evt_rise=1; pending[2] clears after accept; rr_ptr=3.
- Simultaneous rising edges on ch0..ch3 (mode 01), rr_ptr=0, evt_ready=1 → ids 0,1,2,3 in order, one every 2 cycles, then evt_valid=0.
- ch1 mode 10, evt_ready=0: falling edge, then rising, then falling → single event id=1 evt_rise=0; ovf[1]=1 after the second falling edge; ovf_clr[1] pulse → ovf[1]=0.
- ch0 mode 11, event offered with evt_ready=1, new edge on ch0 in the accept cycle → pending[0] stays 1, ovf[0]=0, a second event is emitted with the new direction.
- Reset asserted during OFFER with 3 pending → next cycle evt_valid=0, pending=0, ovf=0, evt_id=0.
